// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Serial boot loader. Receives a framed program image from the console UART
//   and writes it as big-endian 32-bit words into the instruction RAM. The CPU
//   is held in reset until a frame completes with a good checksum. Afterwards
//   one status byte is sent back to the host: 'K' for success, 'E' for failure.
//   Frame: SYNC, LEN_HI, LEN_LO, 4*N data bytes, CSUM (8-bit sum of the data).
// Ports
//   i_clk, i_resetn       clock, synchronous active-low reset
//   i_rx_valid, i_rx_byte received byte from UART
//   o_rx_ack              1-cycle consume pulse to UART
//   o_tx_byte, o_tx_we    reply byte / write request to UART
//   i_tx_wait             UART busy; write accepted when o_tx_we && !i_tx_wait
//   o_mem_we/addr/wdata   instruction RAM write port
//   o_cpu_hold            1 = CPU held in reset
//   o_done, o_err         status of the last frame
module uart_prog_loader #(
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned MEM_WORDS      = 2048,
  parameter int unsigned TIMEOUT_CYCLES = 1600000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_byte,
  output logic              o_rx_ack,
  output logic [7:0]        o_tx_byte,
  output logic              o_tx_we,
  input  logic              i_tx_wait,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_REPLY, S_TXWAIT
  } state_t;

  localparam logic [7:0] CODE_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] CODE_ERR = 8'h45;  // 'E'

  state_t      r_state;
  logic        r_rx_ack;
  logic [7:0]  r_tx_byte;
  logic        r_tx_we;
  logic        r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_cpu_hold;
  logic        r_done;
  logic        r_err;
  logic [15:0] r_len;
  logic [15:0] r_widx;
  logic [1:0]  r_bidx;
  logic [23:0] r_word;
  logic [7:0]  r_sum;
  logic [7:0]  r_code;
  logic [31:0] r_to;

  logic        w_rx_state;
  logic        w_in_frame;
  logic        w_take;
  logic        w_timeout;
  logic [15:0] w_len;
  logic [31:0] w_word_nxt;

  always_comb begin
    w_rx_state = (r_state == S_IDLE) || (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                 (r_state == S_DATA) || (r_state == S_CSUM);
    w_in_frame = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                 (r_state == S_DATA) || (r_state == S_CSUM);
    // r_rx_ack gates the take so a byte still presented during its ack cycle
    // is not consumed twice.
    w_take     = i_rx_valid && !r_rx_ack && w_rx_state;
    w_timeout  = w_in_frame && !w_take && (r_to == 32'(TIMEOUT_CYCLES - 1));
    w_len      = {r_len[15:8], i_rx_byte};
    w_word_nxt = {r_word, i_rx_byte};
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state     <= S_IDLE;
      r_rx_ack    <= 1'b0;
      r_tx_byte   <= '0;
      r_tx_we     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_len       <= '0;
      r_widx      <= '0;
      r_bidx      <= '0;
      r_word      <= '0;
      r_sum       <= '0;
      r_code      <= '0;
      r_to        <= '0;
    end else begin
      r_rx_ack <= w_take;
      r_mem_we <= 1'b0;

      if (w_take)
        r_to <= '0;
      else if (w_in_frame)
        r_to <= r_to + 32'd1;

      case (r_state)
        S_IDLE: begin
          if (w_take && (i_rx_byte == SYNC_BYTE)) begin
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_sum      <= '0;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_take) begin
            r_len[15:8] <= i_rx_byte;
            r_state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_take) begin
            r_len[7:0] <= i_rx_byte;
            if (w_len > 16'(MEM_WORDS)) begin
              r_code  <= CODE_ERR;
              r_state <= S_REPLY;
            end else if (w_len == 16'd0) begin
              r_state <= S_CSUM;
            end else begin
              r_widx  <= '0;
              r_bidx  <= '0;
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_take) begin
            r_word <= w_word_nxt[23:0];
            r_sum  <= r_sum + i_rx_byte;
            r_bidx <= r_bidx + 2'd1;
            if (r_bidx == 2'd3) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_widx[ADDR_W-1:0];
              r_mem_wdata <= w_word_nxt;
              r_widx      <= r_widx + 16'd1;
              if (r_widx == r_len - 16'd1)
                r_state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (w_take) begin
            r_code  <= (i_rx_byte == r_sum) ? CODE_OK : CODE_ERR;
            r_state <= S_REPLY;
          end
        end
        S_REPLY: begin
          r_tx_byte <= r_code;
          r_tx_we   <= 1'b1;
          r_state   <= S_TXWAIT;
        end
        S_TXWAIT: begin
          if (!i_tx_wait) begin
            r_tx_we <= 1'b0;
            if (r_code == CODE_OK) begin
              r_cpu_hold <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Timeout only fires in frame states without a take, so it never
      // collides with the per-state updates above.
      if (w_timeout) begin
        r_code  <= CODE_ERR;
        r_state <= S_REPLY;
      end
    end
  end

  assign o_rx_ack    = r_rx_ack;
  assign o_tx_byte   = r_tx_byte;
  assign o_tx_we     = r_tx_we;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_cpu_hold  = r_cpu_hold;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned MEMW   = 2048;
  localparam int unsigned TMO    = 100;

  logic              clk = 1'b0;
  logic              resetn;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              rx_ack;
  logic [7:0]        tx_byte;
  logic              tx_we;
  logic              tx_wait;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  uart_prog_loader #(
    .ADDR_W(ADDR_W), .MEM_WORDS(MEMW), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)
  ) dut (
    .i_clk(clk), .i_resetn(resetn),
    .i_rx_valid(rx_valid), .i_rx_byte(rx_byte), .o_rx_ack(rx_ack),
    .o_tx_byte(tx_byte), .o_tx_we(tx_we), .i_tx_wait(tx_wait),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_cpu_hold(cpu_hold), .o_done(done), .o_err(err)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // Monitor, sampled on the falling edge.
  int unsigned ack_cnt  = 0;
  int unsigned acc_cnt  = 0;
  int unsigned held_cnt = 0;
  logic [7:0]  last_tx  = '0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  always @(negedge clk) begin
    if (resetn) begin
      if (mem_we) begin
        wa.push_back(32'(mem_addr));
        wd.push_back(mem_wdata);
      end
      if (rx_ack) ack_cnt++;
      if (tx_we && !tx_wait) begin
        acc_cnt++;
        last_tx = tx_byte;
      end
      if (tx_we && tx_wait) held_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rx_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("rx_ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_reply(input int unsigned start, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (acc_cnt != start) break;
    end
    chk("reply_arrived", acc_cnt - start, 32'd1);
  endtask

  function automatic logic [7:0] big_b(input int unsigned j);
    return 8'(j * 7 + 3);
  endfunction

  typedef struct {
    int unsigned nb;
    logic [7:0]  b [12];
    logic [7:0]  reply;
    int unsigned nwr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        hold;
    logic        dn;
    logic        er;
  } vec_t;

  localparam int NV = 5;
  vec_t v [NV];

  initial begin
    int unsigned a0, c0, h0;
    int unsigned bad;
    logic [7:0]  s;

    // T1 good frame, T2 bad checksum, T3 junk then empty frame,
    // T4 oversize length, T5 single word byte order.
    v[0].nb = 12; v[0].b = '{8'hA5,8'h00,8'h02,8'h60,8'h00,8'h00,8'h05,8'h20,8'h00,8'h00,8'h00,8'h85};
    v[0].reply = 8'h4B; v[0].nwr = 2; v[0].w0 = 32'h60000005; v[0].w1 = 32'h20000000;
    v[0].hold = 1'b0; v[0].dn = 1'b1; v[0].er = 1'b0;
    v[1].nb = 12; v[1].b = '{8'hA5,8'h00,8'h02,8'h60,8'h00,8'h00,8'h05,8'h20,8'h00,8'h00,8'h00,8'h86};
    v[1].reply = 8'h45; v[1].nwr = 2; v[1].w0 = 32'h60000005; v[1].w1 = 32'h20000000;
    v[1].hold = 1'b1; v[1].dn = 1'b0; v[1].er = 1'b1;
    v[2].nb = 7;  v[2].b = '{8'h00,8'hFF,8'h13,8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
    v[2].reply = 8'h4B; v[2].nwr = 0; v[2].w0 = '0; v[2].w1 = '0;
    v[2].hold = 1'b0; v[2].dn = 1'b1; v[2].er = 1'b0;
    v[3].nb = 3;  v[3].b = '{8'hA5,8'h08,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
    v[3].reply = 8'h45; v[3].nwr = 0; v[3].w0 = '0; v[3].w1 = '0;
    v[3].hold = 1'b1; v[3].dn = 1'b0; v[3].er = 1'b1;
    v[4].nb = 8;  v[4].b = '{8'hA5,8'h00,8'h01,8'hDE,8'hAD,8'hBE,8'hEF,8'h38,8'h00,8'h00,8'h00,8'h00};
    v[4].reply = 8'h4B; v[4].nwr = 1; v[4].w0 = 32'hDEADBEEF; v[4].w1 = '0;
    v[4].hold = 1'b0; v[4].dn = 1'b1; v[4].er = 1'b0;

    resetn = 1'b0; rx_valid = 1'b0; rx_byte = '0; tx_wait = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_tx_we", 32'(tx_we), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int unsigned i = 0; i < NV; i++) begin
      wa.delete(); wd.delete();
      a0 = ack_cnt; c0 = acc_cnt;
      for (int unsigned j = 0; j < v[i].nb; j++) send_byte(v[i].b[j]);
      wait_reply(c0, 500);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_reply", i), 32'(last_tx), 32'(v[i].reply));
      chk($sformatf("v%0d_acks", i), ack_cnt - a0, v[i].nb);
      chk($sformatf("v%0d_nwr", i), 32'(wa.size()), v[i].nwr);
      if (v[i].nwr > 0) begin
        chk($sformatf("v%0d_a0", i), wa[0], 32'd0);
        chk($sformatf("v%0d_w0", i), wd[0], v[i].w0);
      end
      if (v[i].nwr > 1) begin
        chk($sformatf("v%0d_a1", i), wa[1], 32'd1);
        chk($sformatf("v%0d_w1", i), wd[1], v[i].w1);
      end
      chk($sformatf("v%0d_hold", i), 32'(cpu_hold), 32'(v[i].hold));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(v[i].dn));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(v[i].er));
      chk($sformatf("v%0d_txwe_low", i), 32'(tx_we), 32'd0);
    end

    // Timeout: partial word, then silence.
    wa.delete(); wd.delete();
    c0 = acc_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (tx_we) bad++;
    end
    chk("tmo_not_early", bad, 32'd0);
    wait_reply(c0, 300);
    repeat (3) @(negedge clk);
    chk("tmo_reply", 32'(last_tx), 32'h45);
    chk("tmo_nwr", 32'(wa.size()), 32'd0);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_hold", 32'(cpu_hold), 32'd1);

    // Reply back-pressure, with a byte left pending during the reply.
    wa.delete(); wd.delete();
    @(posedge clk); #1;
    tx_wait = 1'b1;
    for (int unsigned j = 0; j < v[0].nb; j++) send_byte(v[0].b[j]);
    a0 = ack_cnt; c0 = acc_cnt; h0 = held_cnt;
    rx_valid = 1'b1; rx_byte = 8'h00;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx_we) break;
    end
    repeat (49) @(negedge clk);
    @(posedge clk); #1;
    chk("bp_no_ack", ack_cnt - a0, 32'd0);
    chk("bp_no_accept", acc_cnt - c0, 32'd0);
    tx_wait = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      if (ack_cnt != a0) break;
    end
    #1;
    rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("bp_held", held_cnt - h0, 32'd50);
    chk("bp_accepts", acc_cnt - c0, 32'd1);
    chk("bp_reply", 32'(last_tx), 32'h4B);
    chk("bp_pending_acked", ack_cnt - a0, 32'd1);
    chk("bp_nwr", 32'(wa.size()), 32'd2);
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_txwe_low", 32'(tx_we), 32'd0);

    // Reset in the middle of DATA.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    @(posedge clk); #1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mr_rx_ack", 32'(rx_ack), 32'd0);
    chk("mr_tx_we", 32'(tx_we), 32'd0);
    chk("mr_tx_byte", 32'(tx_byte), 32'd0);
    chk("mr_mem_we", 32'(mem_we), 32'd0);
    chk("mr_mem_addr", 32'(mem_addr), 32'd0);
    chk("mr_mem_wdata", mem_wdata, 32'd0);
    chk("mr_hold", 32'(cpu_hold), 32'd1);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Largest legal image: N = MEMW words.
    wa.delete(); wd.delete();
    c0 = acc_cnt;
    s = '0;
    send_byte(8'hA5); send_byte(8'(MEMW >> 8)); send_byte(8'(MEMW));
    for (int unsigned j = 0; j < 4 * MEMW; j++) begin
      send_byte(big_b(j));
      s = s + big_b(j);
    end
    send_byte(s);
    wait_reply(c0, 500);
    repeat (3) @(negedge clk);
    chk("max_reply", 32'(last_tx), 32'h4B);
    chk("max_nwr", 32'(wa.size()), MEMW);
    bad = 0;
    for (int unsigned k = 0; k < wa.size(); k++) begin
      if (wa[k] != k) bad++;
      if (wd[k] != {big_b(4*k), big_b(4*k+1), big_b(4*k+2), big_b(4*k+3)}) bad++;
    end
    chk("max_seq_errors", bad, 32'd0);
    chk("max_last_addr", wa[wa.size()-1], MEMW - 1);
    chk("max_done", 32'(done), 32'd1);
    chk("max_hold", 32'(cpu_hold), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
